// File: rtl/vid_mem_responder.sv
// ---------------------------------------------------------------------------
// vid_mem_responder
//   Bus target for the video controller's read/write protocol. Stores write
//   bursts in an internal word memory. Returns read bursts after a
//   programmable latency. It bids for the shared bus via reqout/ackin before
//   driving any response.
//
// Ports
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   selin             : target selected for the current address phase
//   cmdin[2:0]        : IDLE/WDATA/RD/RDATA/WR/WRESP bus command
//   lenin[1:0]        : burst length code (1/2/4/8 beats)
//   addrdatain[31:0]  : byte address (address phase) or write data (WDATA)
//   ackin             : arbiter grant for our bid
//   reqout[1:0]       : bus bid (PRIO while requesting/owning the bus)
//   lenout[1:0]       : length code of the response being driven
//   addrdataout[31:0] : read data beat, 0 when not driving
//   cmdout[2:0]       : RDATA/WRESP while driving, else IDLE
//   reqtar[3:0]       : TAR_ID while driving, else 0
// ---------------------------------------------------------------------------
module vid_mem_responder #(
    parameter int         DEPTH      = 1024,
    parameter int         RD_LATENCY = 2,
    parameter logic [3:0] TAR_ID     = 4'h1,
    parameter logic [1:0] PRIO       = 2'b11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [1:0]  lenin,
    input  logic [31:0] addrdatain,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic [2:0]  cmdout,
    output logic [3:0]  reqtar
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] CMD_IDLE  = 3'b000;
    localparam logic [2:0] CMD_WDATA = 3'b001;
    localparam logic [2:0] CMD_RD    = 3'b010;
    localparam logic [2:0] CMD_RDATA = 3'b011;
    localparam logic [2:0] CMD_WR    = 3'b100;
    localparam logic [2:0] CMD_WRESP = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_DATA, S_WR_BID, S_WR_RESP, S_RD_WAIT, S_RD_BID, S_RD_BURST
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [3:0]      rem_q, rem_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      len_q, len_d;

    logic [1:0]      reqout_q, reqout_d;
    logic [1:0]      lenout_q, lenout_d;
    logic [31:0]     data_q, data_d;
    logic [2:0]      cmdout_q, cmdout_d;
    logic [3:0]      reqtar_q, reqtar_d;

    logic            mem_we;
    logic [31:0]     mem [DEPTH];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        reqout_d = 2'b00;
        lenout_d = 2'b00;
        data_d   = 32'h0;
        cmdout_d = CMD_IDLE;
        reqtar_d = 4'h0;
        mem_we   = 1'b0;

        // Output registers hold the value for the cycle after this edge, so
        // each branch sets the outputs that belong to the *next* state.
        unique case (state_q)
            S_IDLE: begin
                if (selin && (cmdin == CMD_WR || cmdin == CMD_RD)) begin
                    idx_d = addrdatain[AW+1:2];
                    len_d = lenin;
                    rem_d = 4'd1 << lenin;
                    if (cmdin == CMD_WR) begin
                        state_d = S_WR_DATA;
                    end else begin
                        cnt_d   = 4'(RD_LATENCY);
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_WR_DATA: begin
                if (cmdin == CMD_WDATA) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    rem_d  = rem_q - 4'd1;
                    if (rem_q == 4'd1) begin
                        state_d  = S_WR_BID;
                        reqout_d = PRIO;
                    end
                end
            end
            S_WR_BID: begin
                reqout_d = PRIO;
                if (ackin) begin
                    state_d  = S_WR_RESP;
                    cmdout_d = CMD_WRESP;
                    reqtar_d = TAR_ID;
                    lenout_d = len_q;
                end
            end
            S_WR_RESP: begin
                state_d = S_IDLE;
            end
            S_RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d  = S_RD_BID;
                    reqout_d = PRIO;
                end
            end
            S_RD_BID: begin
                reqout_d = PRIO;
                if (ackin) state_d = S_RD_BURST;
            end
            S_RD_BURST: begin
                // Bid stays up through the last beat; it drops on the edge
                // after, once the state is back in IDLE.
                reqout_d = PRIO;
                if (ackin) begin
                    cmdout_d = CMD_RDATA;
                    data_d   = mem[idx_q];
                    lenout_d = len_q;
                    reqtar_d = TAR_ID;
                    idx_d    = idx_q + 1'b1;
                    rem_d    = rem_q - 4'd1;
                    if (rem_q == 4'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            rem_q    <= 4'h0;
            cnt_q    <= 4'h0;
            len_q    <= 2'b00;
            reqout_q <= 2'b00;
            lenout_q <= 2'b00;
            data_q   <= 32'h0;
            cmdout_q <= CMD_IDLE;
            reqtar_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            reqout_q <= reqout_d;
            lenout_q <= lenout_d;
            data_q   <= data_d;
            cmdout_q <= cmdout_d;
            reqtar_q <= reqtar_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= addrdatain;
    end

    assign reqout      = reqout_q;
    assign lenout      = lenout_q;
    assign addrdataout = data_q;
    assign cmdout      = cmdout_q;
    assign reqtar      = reqtar_q;

endmodule

// File: tb/tb_vid_mem_responder.sv
module tb_vid_mem_responder;

    localparam logic [2:0] C_IDLE  = 3'b000;
    localparam logic [2:0] C_WDATA = 3'b001;
    localparam logic [2:0] C_RD    = 3'b010;
    localparam logic [2:0] C_RDATA = 3'b011;
    localparam logic [2:0] C_WR    = 3'b100;
    localparam logic [2:0] C_WRESP = 3'b101;
    localparam logic [1:0] P       = 2'b11;
    localparam logic [3:0] T       = 4'h1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        selin = 1'b0;
    logic [2:0]  cmdin = 3'b000;
    logic [1:0]  lenin = 2'b00;
    logic [31:0] addrdatain = 32'h0;
    logic        ackin = 1'b0;
    logic [1:0]  reqout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic [2:0]  cmdout;
    logic [3:0]  reqtar;

    int errors = 0;
    int checks = 0;

    vid_mem_responder #(
        .DEPTH(1024), .RD_LATENCY(2), .TAR_ID(4'h1), .PRIO(2'b11)
    ) dut (
        .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin), .lenin(lenin),
        .addrdatain(addrdatain), .ackin(ackin), .reqout(reqout), .lenout(lenout),
        .addrdataout(addrdataout), .cmdout(cmdout), .reqtar(reqtar)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sel;
        logic [2:0]  cmd;
        logic [1:0]  len;
        logic [31:0] ad;
        logic        ack;
        logic [1:0]  er;
        logic [1:0]  el;
        logic [31:0] ed;
        logic [2:0]  ec;
        logic [3:0]  et;
    } vec_t;

    vec_t tbl [10];

    // Apply inputs for one cycle; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic s, input logic [2:0] c, input logic [1:0] l,
                       input logic [31:0] a, input logic k);
        selin = s; cmdin = c; lenin = l; addrdatain = a; ackin = k;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [1:0] er, input logic [1:0] el,
                       input logic [31:0] ed, input logic [2:0] ec, input logic [3:0] et);
        checks++;
        if ({reqout, lenout, addrdataout, cmdout, reqtar} !== {er, el, ed, ec, et}) begin
            errors++;
            $display("FAIL %s: got req=%0h len=%0h data=%h cmd=%0h tar=%0h, want req=%0h len=%0h data=%h cmd=%0h tar=%0h",
                     nm, reqout, lenout, addrdataout, cmdout, reqtar, er, el, ed, ec, et);
        end
    endtask

    // Write burst; data beat i = d0 + i*step. sel=0 checks the request is ignored.
    task automatic wr_burst(input logic s, input logic [31:0] addr, input logic [1:0] l,
                            input logic [31:0] d0, input logic [31:0] step);
        int n;
        n = 1 << l;
        cyc(s, C_WR, l, addr, 1'b0);
        chk("wr_addr", 2'b00, 2'b00, 32'h0, C_IDLE, 4'h0);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, C_WDATA, 2'b00, d0 + step * 32'(i), 1'b0);
            chk("wr_data", (s && i == n - 1) ? P : 2'b00, 2'b00, 32'h0, C_IDLE, 4'h0);
        end
        cyc(1'b0, C_IDLE, 2'b00, 32'h0, 1'b1);
        if (s) chk("wresp", P, l, 32'h0, C_WRESP, T);
        else   chk("no_wresp", 2'b00, 2'b00, 32'h0, C_IDLE, 4'h0);
        cyc(1'b0, C_IDLE, 2'b00, 32'h0, 1'b0);
        chk("wr_done", 2'b00, 2'b00, 32'h0, C_IDLE, 4'h0);
    endtask

    // Read burst; expects beat i = d0 + i*step. Optional 2-cycle grant stall
    // after beat stall_after, a dropped RD while waiting, or reset after beat abort_at.
    task automatic rd_burst(input logic [31:0] addr, input logic [1:0] l,
                            input logic [31:0] d0, input logic [31:0] step,
                            input int stall_after, input logic busy, input int abort_at);
        int n;
        n = 1 << l;
        cyc(1'b1, C_RD, l, addr, 1'b1);
        chk("rd_addr", 2'b00, 2'b00, 32'h0, C_IDLE, 4'h0);
        if (busy) cyc(1'b1, C_RD, 2'b00, 32'h0, 1'b1);
        else      cyc(1'b0, C_IDLE, 2'b00, 32'h0, 1'b1);
        chk("rd_wait", 2'b00, 2'b00, 32'h0, C_IDLE, 4'h0);
        cyc(1'b0, C_IDLE, 2'b00, 32'h0, 1'b1);
        chk("rd_bid", P, 2'b00, 32'h0, C_IDLE, 4'h0);
        cyc(1'b0, C_IDLE, 2'b00, 32'h0, 1'b1);
        chk("rd_grant", P, 2'b00, 32'h0, C_IDLE, 4'h0);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, C_IDLE, 2'b00, 32'h0, 1'b1);
            chk("rd_beat", P, l, d0 + step * 32'(i), C_RDATA, T);
            if (i == abort_at) begin
                #2 reset = 1'b1;
                #1 chk("rst_async", 2'b00, 2'b00, 32'h0, C_IDLE, 4'h0);
                #1 reset = 1'b0;
                return;
            end
            if (i == stall_after) begin
                for (int s = 0; s < 2; s++) begin
                    cyc(1'b0, C_IDLE, 2'b00, 32'h0, 1'b0);
                    chk("rd_stall", P, 2'b00, 32'h0, C_IDLE, 4'h0);
                end
            end
        end
        cyc(1'b0, C_IDLE, 2'b00, 32'h0, 1'b1);
        chk("rd_end", 2'b00, 2'b00, 32'h0, C_IDLE, 4'h0);
        if (busy) begin
            for (int i = 0; i < 6; i++) begin
                cyc(1'b0, C_IDLE, 2'b00, 32'h0, 1'b1);
                chk("no_second_burst", 2'b00, 2'b00, 32'h0, C_IDLE, 4'h0);
            end
        end
    endtask

    initial begin
        // Single write then read of 0x100, ackin high through the read.
        //            sel   cmd      len    ad              ack   er     el     ed             ec       et
        tbl[0] = '{1'b1, C_WR,    2'b00, 32'h0000_0100, 1'b0, 2'b00, 2'b00, 32'h0,         C_IDLE,  4'h0};
        tbl[1] = '{1'b0, C_WDATA, 2'b00, 32'hA5A5_0001, 1'b0, P,     2'b00, 32'h0,         C_IDLE,  4'h0};
        tbl[2] = '{1'b0, C_IDLE,  2'b00, 32'h0,         1'b1, P,     2'b00, 32'h0,         C_WRESP, T};
        tbl[3] = '{1'b0, C_IDLE,  2'b00, 32'h0,         1'b1, 2'b00, 2'b00, 32'h0,         C_IDLE,  4'h0};
        tbl[4] = '{1'b1, C_RD,    2'b00, 32'h0000_0100, 1'b1, 2'b00, 2'b00, 32'h0,         C_IDLE,  4'h0};
        tbl[5] = '{1'b0, C_IDLE,  2'b00, 32'h0,         1'b1, 2'b00, 2'b00, 32'h0,         C_IDLE,  4'h0};
        tbl[6] = '{1'b0, C_IDLE,  2'b00, 32'h0,         1'b1, P,     2'b00, 32'h0,         C_IDLE,  4'h0};
        tbl[7] = '{1'b0, C_IDLE,  2'b00, 32'h0,         1'b1, P,     2'b00, 32'h0,         C_IDLE,  4'h0};
        tbl[8] = '{1'b0, C_IDLE,  2'b00, 32'h0,         1'b1, P,     2'b00, 32'hA5A5_0001, C_RDATA, T};
        tbl[9] = '{1'b0, C_IDLE,  2'b00, 32'h0,         1'b1, 2'b00, 2'b00, 32'h0,         C_IDLE,  4'h0};

        repeat (2) @(posedge clk);
        #1 chk("reset", 2'b00, 2'b00, 32'h0, C_IDLE, 4'h0);
        #3 reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].sel, tbl[i].cmd, tbl[i].len, tbl[i].ad, tbl[i].ack);
            chk($sformatf("tbl%0d", i), tbl[i].er, tbl[i].el, tbl[i].ed, tbl[i].ec, tbl[i].et);
        end

        // Four-beat burst.
        wr_burst(1'b1, 32'h200, 2'b10, 32'h11, 32'h11);
        rd_burst(32'h200, 2'b10, 32'h11, 32'h11, -1, 1'b0, -1);

        // Index wraps from 1023 to 0.
        wr_burst(1'b1, 32'hFFC, 2'b01, 32'd7, 32'd1);
        rd_burst(32'h000, 2'b00, 32'd8, 32'd0, -1, 1'b0, -1);
        rd_burst(32'hFFC, 2'b00, 32'd7, 32'd0, -1, 1'b0, -1);

        // Eight-beat read with grant dropped for 2 cycles after beat 3.
        wr_burst(1'b1, 32'h400, 2'b11, 32'h1000, 32'h10);
        rd_burst(32'h400, 2'b11, 32'h1000, 32'h10, 3, 1'b0, -1);

        // Second RD during the latency wait is dropped.
        rd_burst(32'h200, 2'b10, 32'h11, 32'h11, -1, 1'b1, -1);

        // Unselected WR: no response, memory at 0x100 unchanged.
        wr_burst(1'b0, 32'h100, 2'b00, 32'hDEAD_0000, 32'h0);
        rd_burst(32'h100, 2'b00, 32'hA5A5_0001, 32'h0, -1, 1'b0, -1);

        // Reset during beat 2, then the data must still read back intact.
        wr_burst(1'b1, 32'h300, 2'b11, 32'h300, 32'h1);
        rd_burst(32'h300, 2'b11, 32'h300, 32'h1, -1, 1'b0, 2);
        cyc(1'b0, C_IDLE, 2'b00, 32'h0, 1'b1);
        chk("post_rst_idle", 2'b00, 2'b00, 32'h0, C_IDLE, 4'h0);
        rd_burst(32'h300, 2'b11, 32'h300, 32'h1, -1, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
